// File: rtl/div_unit_pkg.sv
// Shared defines for the iterative divider: FSM encodings, handshake levels
// and the sign helpers used at operand capture and result formation.
package div_unit_pkg;

    localparam logic        RstEnable         = 1'b1;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Magnitude of a word; only treated as signed when is_signed is set.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] negate_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the pipeline (master) and the divider (slave).
// Handshake: the master raises start_i with stable operands and keeps it high
// until it has consumed ready_o; dropping start_i releases or aborts the divider.
interface div_unit_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider, 32 iterations per operation, signed or unsigned.
// result_o = {remainder, quotient}; both outputs are registered.
module div_unit
    import div_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus,
    output div_state_e dbg_state
);

    div_state_e  state;
    logic [5:0]  cnt;
    logic [63:0] work;      // {partial remainder, quotient/dividend bits}
    logic [31:0] divisor;
    logic        neg_quo;
    logic        neg_rem;
    logic [63:0] result;
    logic        ready;

    logic [32:0] cand;
    logic [32:0] trial;
    logic [63:0] next_work;
    logic        abort;

    // The shifted remainder needs 33 bits; since it is below 2*divisor,
    // bit 32 of the 33-bit trial difference is a valid sign.
    always_comb begin
        cand      = work[63:31];
        trial     = cand - {1'b0, divisor};
        next_work = work;
        if (trial[32]) begin
            next_work = {cand[31:0], work[30:0], 1'b0};
        end else begin
            next_work = {trial[31:0], work[30:0], 1'b1};
        end
        abort = bus.annul_i || (bus.start_i == DivStop);
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state   <= DivFree;
            cnt     <= 6'd0;
            work    <= 64'd0;
            divisor <= ZeroWord;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            result  <= {ZeroWord, ZeroWord};
            ready   <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    ready  <= DivResultNotReady;
                    result <= {ZeroWord, ZeroWord};
                    if (bus.start_i == DivStart && !bus.annul_i) begin
                        if (bus.opdata2_i == ZeroWord) begin
                            state <= DivByZero;
                        end else begin
                            state   <= DivOn;
                            cnt     <= 6'd0;
                            work    <= {ZeroWord, magnitude(bus.opdata1_i, bus.signed_div_i)};
                            divisor <= magnitude(bus.opdata2_i, bus.signed_div_i);
                            neg_quo <= bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                            neg_rem <= bus.signed_div_i & bus.opdata1_i[31];
                        end
                    end
                end
                DivByZero: begin
                    result <= {ZeroWord, ZeroWord};
                    if (abort) begin
                        state <= DivFree;
                        ready <= DivResultNotReady;
                    end else begin
                        state <= DivEnd;
                        ready <= DivResultReady;
                    end
                end
                DivOn: begin
                    if (abort) begin
                        state  <= DivFree;
                        cnt    <= 6'd0;
                        work   <= 64'd0;
                        ready  <= DivResultNotReady;
                        result <= {ZeroWord, ZeroWord};
                    end else if (cnt != 6'd32) begin
                        work <= next_work;
                        cnt  <= cnt + 6'd1;
                    end else begin
                        result <= {negate_if(work[63:32], neg_rem), negate_if(work[31:0], neg_quo)};
                        ready  <= DivResultReady;
                        state  <= DivEnd;
                        cnt    <= 6'd0;
                    end
                end
                DivEnd: begin
                    // annul_i is deliberately ignored here; only start_i releases.
                    if (bus.start_i == DivStop) begin
                        state  <= DivFree;
                        ready  <= DivResultNotReady;
                        result <= {ZeroWord, ZeroWord};
                    end
                end
                default: begin
                    state  <= DivFree;
                    ready  <= DivResultNotReady;
                    result <= {ZeroWord, ZeroWord};
                end
            endcase
        end
    end

    assign bus.result_o = result;
    assign bus.ready_o  = ready;
    assign dbg_state    = state;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: driver tasks push expected results into a queue,
// an independent monitor pops one entry on every rising ready_o.
module tb_div_unit;
    import div_unit_pkg::*;

    logic       clk;
    logic       rst;
    div_state_e dbg_state;
    div_unit_if bus ();

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic        ready_q = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a rising ready_o must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.ready_o === 1'b1 && ready_q === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", bus.result_o, 64'hxxxx_xxxx_xxxx_xxxx);
            end else begin
                check("sb_result", bus.result_o, exp_q.pop_front());
            end
        end
        ready_q <= bus.ready_o;
    end

    task automatic idle_inputs();
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'h0;
        bus.opdata2_i    = 32'h0;
    endtask

    // One full transaction: latency check, hold in END, release check.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int lat, input int hold);
        int  n;
        bit  got;
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~sgn;
        n   = 0;
        got = 0;
        while (!got && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.ready_o === 1'b1) got = 1;
        end
        check({name, "_latency"}, 64'(n), 64'(lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
            check({name, "_hold_result"}, bus.result_o, exp);
        end
        bus.annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({name, "_annul_in_end"}, 64'(dbg_state), 64'(DivEnd));
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, "_rel_ready"}, 64'(bus.ready_o), 64'd0);
        check({name, "_rel_result"}, bus.result_o, 64'd0);
        check({name, "_rel_state"}, 64'(dbg_state), 64'(DivFree));
    endtask

    // Start 100/7, run `iters` iterations, then abort by mode: 0 annul, 1 start drop, 2 rst.
    task automatic abort_run(input string name, input int iters, input int mode);
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        @(posedge clk);
        repeat (iters) @(posedge clk);
        @(negedge clk);
        check({name, "_mid_state"}, 64'(dbg_state), 64'(DivOn));
        case (mode)
            0: bus.annul_i = 1'b1;
            1: bus.start_i = 1'b0;
            default: rst = 1'b1;
        endcase
        @(posedge clk);
        @(negedge clk);
        check({name, "_state"}, 64'(dbg_state), 64'(DivFree));
        check({name, "_ready"}, 64'(bus.ready_o), 64'd0);
        check({name, "_result"}, bus.result_o, 64'd0);
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready_o !== 1'b0) check({name, "_stray_ready"}, 64'(bus.ready_o), 64'd0);
        end
        check({name, "_quiet"}, 64'(bus.ready_o), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        bus.start_i   = 1'b1;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 64'(dbg_state), 64'(DivFree));
        check("rst_ready", 64'(bus.ready_o), 64'd0);
        check("rst_result", bus.result_o, 64'd0);
        rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        check("post_rst_state", 64'(dbg_state), 64'(DivFree));

        run_div("u_100_7",    1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33, 5);
        run_div("s_m7_2",     1'b1, 32'hFFFFFFF9,  32'h00000002,  64'hFFFFFFFF_FFFFFFFD, 33, 0);
        run_div("s_7_m2",     1'b1, 32'h00000007,  32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33, 0);
        run_div("s_m7_m2",    1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  64'hFFFFFFFF_00000003, 33, 0);
        run_div("u_div0",     1'b0, 32'h12345678,  32'h0,         64'h0,                  1, 2);
        run_div("s_div0",     1'b1, 32'h12345678,  32'h0,         64'h0,                  1, 0);
        run_div("s_ovf",      1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33, 0);
        run_div("u_max_1",    1'b0, 32'hFFFFFFFF,  32'h00000001,  64'h00000000_FFFFFFFF, 33, 0);
        run_div("u_big_dvsr", 1'b0, 32'hFFFFFFFF,  32'h80000001,  64'h7FFFFFFE_00000001, 33, 0);
        run_div("u_small",    1'b0, 32'd5,         32'd9,         64'h00000005_00000000, 33, 0);

        abort_run("annul_it10", 10, 0);
        run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);
        abort_run("drop_it5", 5, 1);
        run_div("after_drop_9_3",  1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);
        abort_run("rst_it20", 20, 2);
        run_div("after_rst_9_3",   1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
